// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shift/rotate unit with a valid/ready handshake.
// The operand is loaded into a work register on accept and moved one bit per
// clock. The result, carry-out and zero flag are registered once the last step
// is done, and they stay stable until the consumer takes them.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] cnt,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             z,
  output logic             busy
);

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_SAR = 3'b100;
  localparam logic [2:0] OP_RCL = 3'b101;
  localparam logic [2:0] OP_RCR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   work_r;
  logic               carry_r;
  logic [CNT_W-1:0]   rem_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   result_r;
  logic               co_r;
  logic               z_r;
  logic               out_valid_r;

  logic               in_ready_s;
  logic               busy_s;
  logic               accept_s;
  logic               step_s;
  logic               load_out_s;
  logic [2:0]         op_dec_s;
  logic               carry_init_s;
  logic [WIDTH:0]     step_val_s;
  logic               co_fin_s;

  // One bit step: returns {new carry, new work value}. Rotates keep the carry.
  function automatic logic [WIDTH:0] step_fn(input logic [2:0] op_v,
                                             input logic [WIDTH-1:0] r,
                                             input logic c);
    logic [WIDTH:0] v;
    case (op_v)
      OP_SHR:  v = {r[0], 1'b0, r[WIDTH-1:1]};
      OP_ROL:  v = {c, r[WIDTH-2:0], r[WIDTH-1]};
      OP_ROR:  v = {c, r[0], r[WIDTH-1:1]};
      OP_SAR:  v = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
      OP_RCL:  v = {r[WIDTH-1], r[WIDTH-2:0], c};
      OP_RCR:  v = {r[0], c, r[WIDTH-1:1]};
      default: v = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
    endcase
    return v;
  endfunction

  // Operand decode: op 111 aliases SHL; only the rotate-through-carry ops seed the carry with cin.
  always_comb begin
    if (op == 3'b111) begin
      op_dec_s = OP_SHL;
    end else begin
      op_dec_s = op;
    end
    if ((op == OP_RCL) || (op == OP_RCR)) begin
      carry_init_s = cin;
    end else begin
      carry_init_s = 1'b0;
    end
  end

  // Single step of the work register and the carry-out chosen when the result is finalised.
  always_comb begin
    step_val_s = step_fn(op_r, work_r, carry_r);
    case (op_r)
      OP_ROL:  co_fin_s = work_r[0];
      OP_ROR:  co_fin_s = work_r[WIDTH-1];
      default: co_fin_s = carry_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides everything, including a same-cycle request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (in_valid) begin
          if (cnt == {CNT_W{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (rem_r == CNT_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (out_valid_r && out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    load_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        accept_s   = in_valid && !flush;
      end
      BUSY: begin
        busy_s = 1'b1;
        step_s = !flush;
      end
      DONE: begin
        busy_s     = 1'b1;
        load_out_s = !flush && !out_valid_r;
      end
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Work register, carry and remaining count: load on accept, step while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      rem_r   <= {CNT_W{1'b0}};
      op_r    <= OP_SHL;
    end else if (accept_s) begin
      work_r  <= a;
      carry_r <= carry_init_s;
      rem_r   <= cnt;
      op_r    <= op_dec_s;
    end else if (step_s) begin
      work_r  <= step_val_s[WIDTH-1:0];
      carry_r <= step_val_s[WIDTH];
      rem_r   <= rem_r - CNT_W'(1);
    end else begin
      work_r  <= work_r;
      carry_r <= carry_r;
      rem_r   <= rem_r;
      op_r    <= op_r;
    end
  end

  // Result/flag registers: captured once in DONE, held until the handshake; flush drops valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {WIDTH{1'b0}};
      co_r        <= 1'b0;
      z_r         <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_out_s) begin
      result_r    <= work_r;
      co_r        <= co_fin_s;
      z_r         <= (work_r == {WIDTH{1'b0}});
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign co        = co_r;
  assign z         = z_r;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH=8): directed cases, flush,
// async reset and randomized operations against an arithmetic reference model.
module tb_shift_unit_seq;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [CW-1:0] cnt;
  logic [2:0]    op;
  logic          cin;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          co;
  logic          z;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int last_res = 0;

  shift_unit_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .cnt(cnt), .op(op), .cin(cin), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .co(co), .z(z), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the whole n-bit shift/rotate done at once with integer arithmetic.
  function automatic void ref_model(input logic [2:0] o, input int av, input int n,
                                    input logic ci, output int res, output int c);
    int mask  = (1 << W) - 1;
    int mask9 = (1 << (W + 1)) - 1;
    int v     = (int'(ci) << W) | av;
    int rot;
    case (o)
      3'd1: begin res = av >> n; c = (n != 0) ? ((av >> (n - 1)) & 1) : 0; end
      3'd2: begin res = ((av << n) | (av >> (W - n))) & mask; c = res & 1; end
      3'd3: begin res = ((av >> n) | (av << (W - n))) & mask; c = (res >> (W - 1)) & 1; end
      3'd4: begin
        if (av >= (1 << (W - 1))) res = ((av | ~mask) >>> n) & mask;
        else res = av >> n;
        c = (n != 0) ? ((av >> (n - 1)) & 1) : 0;
      end
      3'd5: begin
        rot = ((v << n) | (v >> (W + 1 - n))) & mask9;
        res = rot & mask; c = (rot >> W) & 1;
      end
      3'd6: begin
        rot = ((v >> n) | (v << (W + 1 - n))) & mask9;
        res = rot & mask; c = (rot >> W) & 1;
      end
      default: begin res = (av << n) & mask; c = (n != 0) ? ((av >> (W - n)) & 1) : 0; end
    endcase
  endfunction

  // Issue one operation, check latency, flags, backpressure and the handshake.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input int n,
                        input logic ci, input int hold);
    int res, c, lat, k;
    ref_model(o, int'(av), n, ci, res, c);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before", in_ready, 1);
    in_valid = 1'b1; op = o; a = av; cnt = n[CW-1:0]; cin = ci;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); cnt = 3'($urandom); cin = 1'($urandom);
    lat = 0;
    @(negedge clk);
    check("ready_after_accept", in_ready, 0);
    check("busy_after_accept", busy, 1);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, n + 1);
    check("result", result, res);
    check("co", co, c);
    check("z", z, (res == 0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, res);
      check("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_busy", busy, 0);
    last_res = res;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; cnt = '0; op = 3'd0; cin = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_co", co, 0);
    check("rst_z", z, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed cases
    run_op(3'd0, 8'h81, 1, 1'b0, 0);
    run_op(3'd1, 8'h81, 3, 1'b0, 0);
    run_op(3'd4, 8'h80, 7, 1'b0, 0);
    run_op(3'd2, 8'h81, 1, 1'b0, 0);
    run_op(3'd3, 8'h01, 1, 1'b0, 0);
    run_op(3'd5, 8'h80, 1, 1'b0, 0);
    run_op(3'd0, 8'h5A, 0, 1'b0, 0);
    run_op(3'd6, 8'h33, 0, 1'b1, 0);
    run_op(3'd7, 8'hC3, 2, 1'b0, 5);
    run_op(3'd6, 8'h01, 1, 1'b0, 0);

    // Flush mid-BUSY: result keeps its previous value, nothing is emitted
    in_valid = 1'b1; op = 3'd0; a = 8'hFF; cnt = 3'd7; cin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    check("flush_result_kept", result, last_res);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("flush_no_valid", seen, 0);

    // Flush together with a request in IDLE: no accept
    in_valid = 1'b1; flush = 1'b1; cnt = 3'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_vs_req_ready", in_ready, 1);
    check("flush_vs_req_busy", busy, 0);

    // Async reset mid-BUSY
    run_op(3'd5, 8'h80, 0, 1'b1, 0);
    in_valid = 1'b1; op = 3'd1; a = 8'hF0; cnt = 3'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_co", co, 0);
    check("arst_z", z, 0);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd1, 8'h81, 3, 1'b0, 0);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 7)),
             1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
